// File: rtl/cis_dvp_frame_tx.sv
// rtl/cis_dvp_frame_tx.sv - DVP camera-sensor frame transmitter (test patterns or external pixel stream)
module cis_dvp_frame_tx #(
    parameter int DATA_W    = 10,
    parameter int PCLK_DIV  = 2,
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 144,
    parameter int V_ACTIVE  = 480,
    parameter int VSYNC_LEN = 3,
    parameter int V_BACK    = 17,
    parameter int V_FRONT   = 10
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              start_i,
    input  logic              cont_i,
    input  logic [1:0]        pat_sel_i,
    input  logic [DATA_W-1:0] pix_data_i,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    output logic              cis_pclk_o,
    output logic              cis_vsync_o,
    output logic              cis_href_o,
    output logic [DATA_W-1:0] cis_data_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              underflow_o,
    output logic [15:0]       frame_cnt_o
);
    localparam int LINE  = H_ACTIVE + H_BLANK;
    localparam int XW    = $clog2(LINE);
    localparam int DW    = $clog2(PCLK_DIV);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int SW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(PCLK_DIV / 2);
    localparam logic [XW-1:0] X_LAST   = XW'(LINE - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_ACT_M1 = XW'(H_ACTIVE - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(BAR_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

    state_t            state, state_nx;
    logic [XW-1:0]     x, x_nx;
    logic [15:0]       line, line_nx, lines_last;
    logic [2:0]        bar, bar_nx;
    logic [SW-1:0]     sub, sub_nx;
    logic [DW-1:0]     div;
    logic [1:0]        pat;
    logic              tick, start_ok, frame_end, act_nx;
    logic [DATA_W-1:0] data_nx;
    logic [15:0]       ramp_sum, bar_val;

    assign tick       = (state != S_IDLE) && (div == DIV_LAST);
    assign busy_o     = (state != S_IDLE);
    assign cis_pclk_o = (div >= DIV_HALF);

    always_comb begin
        lines_last = 16'd0;
        case (state)
            S_VSYNC:  lines_last = 16'(VSYNC_LEN - 1);
            S_VBACK:  lines_last = 16'(V_BACK - 1);
            S_ACTIVE: lines_last = 16'(V_ACTIVE - 1);
            S_VFRONT: lines_last = 16'(V_FRONT - 1);
            default:  lines_last = 16'd0;
        endcase
    end

    // Position registers describe the pixel currently on the bus; the *_nx
    // values are the pixel launched at the next PCLK falling edge.
    always_comb begin
        state_nx  = state;
        x_nx      = x;
        line_nx   = line;
        bar_nx    = bar;
        sub_nx    = sub;
        start_ok  = 1'b0;
        frame_end = 1'b0;
        if (state == S_IDLE) begin
            if (start_i) begin
                state_nx = S_VSYNC;
                x_nx     = '0;
                line_nx  = 16'd0;
                bar_nx   = 3'd0;
                sub_nx   = '0;
                start_ok = 1'b1;
            end
        end else if (tick) begin
            if (x != X_LAST) begin
                x_nx = x + XW'(1);
                if (x < X_ACT_M1) begin
                    if (sub == SUB_LAST) begin
                        bar_nx = bar + 3'd1;
                        sub_nx = '0;
                    end else begin
                        sub_nx = sub + SW'(1);
                    end
                end
            end else begin
                x_nx   = '0;
                bar_nx = 3'd0;
                sub_nx = '0;
                if (line != lines_last) begin
                    line_nx = line + 16'd1;
                end else begin
                    line_nx = 16'd0;
                    case (state)
                        S_VSYNC:  state_nx = S_VBACK;
                        S_VBACK:  state_nx = S_ACTIVE;
                        S_ACTIVE: state_nx = S_VFRONT;
                        default: begin
                            frame_end = 1'b1;
                            state_nx  = cont_i ? S_VSYNC : S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign act_nx      = (state_nx == S_ACTIVE) && (x_nx < X_ACT);
    assign pix_ready_o = tick && act_nx && (pat == 2'd3);
    assign ramp_sum    = 16'(x_nx) + line_nx;
    assign bar_val     = {13'd0, bar_nx} * 16'd146;

    always_comb begin
        data_nx = '0;
        if (act_nx) begin
            case (pat)
                2'd0:    data_nx = bar_val[DATA_W-1:0];
                2'd1:    data_nx = ramp_sum[DATA_W-1:0];
                2'd2:    data_nx = (x_nx[3] ^ line_nx[3]) ? '1 : '0;
                default: data_nx = pix_valid_i ? pix_data_i : '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state        <= S_IDLE;
            x            <= '0;
            line         <= 16'd0;
            bar          <= 3'd0;
            sub          <= '0;
            div          <= '0;
            pat          <= 2'd0;
            cis_vsync_o  <= 1'b0;
            cis_href_o   <= 1'b0;
            cis_data_o   <= '0;
            frame_done_o <= 1'b0;
            underflow_o  <= 1'b0;
            frame_cnt_o  <= 16'd0;
        end else begin
            state        <= state_nx;
            x            <= x_nx;
            line         <= line_nx;
            bar          <= bar_nx;
            sub          <= sub_nx;
            frame_done_o <= frame_end;
            if (state == S_IDLE || tick)
                div <= '0;
            else
                div <= div + DW'(1);
            if (start_ok || (frame_end && cont_i))
                pat <= pat_sel_i;
            if (start_ok || tick) begin
                cis_vsync_o <= (state_nx == S_VSYNC);
                cis_href_o  <= act_nx;
                cis_data_o  <= data_nx;
            end
            if (frame_end)
                frame_cnt_o <= frame_cnt_o + 16'd1;
            if (start_ok)
                underflow_o <= 1'b0;
            else if (pix_ready_o && !pix_valid_i)
                underflow_o <= 1'b1;
        end
    end
endmodule

// File: doc/cis_dvp_frame_tx.md
Name: cis_dvp_frame_tx

Overview:
- Parallel DVP camera-sensor transmitter: the source end of the CIS interface (PCLK, VSYNC, HSYNC/HREF, D9-D0) that the ISP receives.
- Generates complete frames from an internal test pattern or an external pixel stream.
- Used on-chip for ISP loopback/self-test and to drive an off-chip ISP through GPIO.
- All timing comes from wb_clk_i; PCLK is a divided copy of it.

Parameters:
- DATA_W, 10, pixel data width.
- PCLK_DIV, 2, wb_clk_i cycles per pixel period; even, >=2.
- H_ACTIVE, 640, active pixels per line; multiple of 8.
- H_BLANK, 144, blank pixel periods per line; >=1.
- V_ACTIVE, 480, active lines per frame.
- VSYNC_LEN, 3, lines with VSYNC high.
- V_BACK, 17, blank lines after VSYNC.
- V_FRONT, 10, blank lines after the last active line.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; begins a frame when idle.
- cont_i  in  1  1 = run frames back-to-back while high.
- pat_sel_i  in  2  pattern select: 0 = colour bars, 1 = ramp, 2 = checker, 3 = external stream.
- pix_data_i  in  DATA_W  external pixel.
- pix_valid_i  in  1  external pixel valid.
- pix_ready_o  out  1  external pixel accepted this cycle.
- cis_pclk_o  out  1  pixel clock.
- cis_vsync_o  out  1  frame sync, active high.
- cis_href_o  out  1  line-valid (HSYNC), active high.
- cis_data_o  out  DATA_W  pixel data.
- busy_o  out  1  frame in progress.
- frame_done_o  out  1  one-cycle pulse at the end of each frame.
- underflow_o  out  1  sticky: external pixel missing.
- frame_cnt_o  out  16  frames completed, wraps.

Behaviour:
- Reset (asynchronous, active low): state IDLE, all counters 0, every output 0.
- Pixel tick:
  - Divider counts 0..PCLK_DIV-1 while busy.
  - cis_pclk_o = 0 for counts < PCLK_DIV/2, otherwise 1.
  - VSYNC, HREF and data are registered and change only at count 0, which is the PCLK falling edge. The receiver samples on the rising edge.
- FSM states: IDLE -> VSYNC (VSYNC_LEN lines) -> VBACK (V_BACK lines) -> ACTIVE (V_ACTIVE lines) -> VFRONT (V_FRONT lines).
  - Each line is H_ACTIVE + H_BLANK pixel periods.
  - x counts 0..H_ACTIVE+H_BLANK-1.
  - y counts active lines 0..V_ACTIVE-1.
- Start:
  - start_i in IDLE enters VSYNC on the next cycle.
  - First pixel period begins with cis_vsync_o = 1 and PCLK low.
  - start_i while busy is ignored.
- VSYNC state: cis_vsync_o = 1. All other states: cis_vsync_o = 0.
- HREF: cis_href_o = 1 only in ACTIVE with x < H_ACTIVE.
- Data: cis_data_o = 0 whenever cis_href_o = 0.
- End of frame (last tick of VFRONT):
  - frame_done_o pulses for 1 cycle.
  - frame_cnt_o increments, wrapping 0xFFFF -> 0.
  - If cont_i = 1: go straight to VSYNC with no gap. Else go to IDLE; busy_o drops the same cycle.
- Stopping: clearing cont_i mid-frame never truncates the current frame.
- pat_sel_i is sampled at frame start and held for the whole frame.
- Patterns (evaluated at active pixel x, line y):
  - Bars: bar = x / (H_ACTIVE/8), implemented with a sub-counter, no divider. Data = bar * 146 (0, 146, ..., 1022).
  - Ramp: data = (x + y) mod 2^DATA_W.
  - Checker: data = 0x3FF if x[3] XOR y[3], else 0.
  - External stream:
    - pix_ready_o = 1 for exactly the one cycle of each active-pixel tick.
    - If pix_valid_i = 1 that cycle, the pixel is consumed.
    - If pix_valid_i = 0, output 0 and set underflow_o.
    - underflow_o clears only on an accepted start_i or on reset.
  - In non-external patterns pix_ready_o = 0.
- Reset mid-frame: immediate return to IDLE with all outputs 0; no frame_done_o pulse.

Test Plan:
Unless stated, parameters are PCLK_DIV=2, H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VSYNC_LEN=2, V_BACK=1, V_FRONT=1, giving 192 clocks per frame.
1. Ramp, single frame:
   - Stimulus: pat_sel_i=1, cont_i=0, one start_i pulse.
   - VSYNC high for 48 clocks.
   - Four HREF bursts of 8 pixels; line 2 data = 2, 3, ..., 9.
   - frame_done_o pulses once, 192 clocks after start.
   - frame_cnt_o = 1, then busy_o = 0.
2. Bars with PCLK_DIV=4:
   - Data = 0, 146, ..., 1022 on successive pixels.
   - Each value is stable across a full PCLK period.
   - Transitions occur only on PCLK falling edges.
3. Continuous mode:
   - cont_i=1 for 3 frames, then cleared mid-frame 3.
   - Exactly 3 frame_done_o pulses, 192 clocks apart.
   - No idle gap between frames; frame_cnt_o = 3.
4. External stream underflow:
   - pat_sel_i=3; pix_valid_i held 1 except at pixel (x=5, y=1).
   - That pixel outputs 0 and underflow_o rises and stays 1.
   - pix_ready_o asserts exactly 32 times.
   - A new start_i clears underflow_o.
5. Reset mid-frame and ignored start:
   - Assert wb_rst_n_i=0 during ACTIVE line 2: all outputs go 0 asynchronously and no frame_done_o pulse occurs.
   - After release, a start_i pulse runs a clean frame.
   - start_i pulsed while busy changes nothing.
